tcam_match_array: RTL and testbench
===================================

# tcam_match_array

Storage and compare stage of the TCAM lookup path. Holds ENTRIES ternary entries (data, mask, valid) and, for each search key, produces a registered one-hot-or-multi-hot match-line vector. This vector feeds the downstream 16→4 priority encoder directly on its `D[15:0]` input. Entry writes, per-entry invalidate, global flush and a read-back port are provided for the control plane.

## Interface
- `ENTRIES`, 16 — number of entries; the downstream encoder requires 16.
- `KEY_W`, 8 — key, data and mask width.
- `AW`, $clog2(ENTRIES) — address width (derived, not overridden).

Ports:
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `wr_en` in 1 — write entry `wr_addr` this cycle.
- `wr_addr` in AW — target entry.
- `wr_data` in KEY_W — entry data.
- `wr_mask` in KEY_W — per-bit don't-care; 1 = ignore bit.
- `wr_valid` in 1 — valid bit written with the entry; 0 = invalidate.
- `flush` in 1 — clear every valid bit.
- `srch_valid` in 1 — search request; `srch_key` is sampled this cycle.
- `srch_key` in KEY_W — search key.
- `match` out ENTRIES — match lines; bit i set iff entry i hit.
- `match_valid` out 1 — `match` belongs to a search issued 2 cycles earlier.
- `hit` out 1 — OR-reduction of `match`, registered with it.
- `rd_addr` in AW — read-back address.
- `rd_data` out KEY_W, `rd_mask` out KEY_W, `rd_ent_valid` out 1 — entry contents, 1-cycle latency.

## Operation
- **Match rule:** entry i hits iff `valid[i]` and `((key ^ data[i]) & ~mask[i]) == 0`. A mask of all ones with valid set is a wildcard that matches every key.
- **Pipeline:**
  - Stage 1 registers `srch_key` and `srch_valid` at the edge ending cycle N.
  - Stage 2 compares the registered key against array state during cycle N+1 and registers `match`, `hit` and `match_valid` at the edge ending N+1.
  - No backpressure; one search accepted per cycle; fully pipelined.
- **Idle:** when a stage holds no valid search, `match` = 0, `hit` = 0 and `match_valid` = 0. Outputs never hold stale hits.
- **Write:** commits at the edge ending the cycle in which `wr_en` = 1. `data`, `mask` and `valid` are all updated.
- **Flush:** clears all valid bits at the edge. Data and mask are retained.
- **Simultaneous flush and wr_en:** the write wins for `wr_addr`; all other entries are cleared.
- **Write/search visibility:**
  - A write or flush in the same cycle as `srch_valid` IS visible to that search.
  - A write or flush in the cycle after `srch_valid` is NOT visible.
- **Read-back:** registered read of `rd_addr`. A write to the same address in the same cycle returns the old contents.
- **Reset (asynchronous):**
  - All valid bits cleared; data and mask cleared to 0.
  - Pipeline valids cleared.
  - Outputs: `match` = 0, `hit` = 0, `match_valid` = 0, `rd_data` = 0, `rd_mask` = 0, `rd_ent_valid` = 0.
  - Searches in flight when reset asserts are dropped, never emitted.

## Timing
- Search latency: 2 cycles, `srch_valid` at N → `match_valid` at N+2.
- Write-to-search visibility: 0 cycles, same-cycle search sees the write.
- Read latency: 1 cycle.
- Throughput: 1 search per cycle, concurrent with 1 write and 1 read.
- Compare path: KEY_W-wide XOR/AND, then an ENTRIES-wide reduction. It must close timing in a single stage.

## Structure
- **Shared package `tcam_pkg`:**
  - Constants `TCAM_ENTRIES` = 16 and `TCAM_KEY_W` = 8.
  - Struct `tcam_entry_t` with fields {data, mask, valid}.
  - The downstream encoder and the lookup controller use the same package.
- **Sub-module `tcam_cell`:** one entry. It holds its registers and write decode and outputs its match bit. Instantiate it ENTRIES times through a generate loop.
- The pipeline registers and read mux stay in the top module.

## Test plan
- **Reset then search:** after reset, search `8'hAA` → `match` = 0, `hit` = 0 and `match_valid` = 1 at N+2. Before N+2, `match_valid` = 0.
- **Exact and wildcard:**
  - Setup: entry 3 = {8'h5A, mask 8'h00, valid}; entry 12 = {8'h50, mask 8'h0F, valid}.
  - Search `8'h5A` → `match` = 16'h1008.
  - Search `8'h57` → `match` = 16'h1000.
  - Search `8'h60` → `match` = 0.
- **Same-cycle write and search:** write entry 7 = {8'h11, 8'h00, valid} in the same cycle as search `8'h11` → `match[7]` = 1 at N+2. The same write issued one cycle after the search → `match[7]` = 0.
- **Flush/write collision:** entries 0–15 all valid wildcards; in one cycle assert flush and write entry 5 (wildcard, valid). The next search → `match` = 16'h0020.
- **Back-to-back searches:** 4 consecutive keys → 4 consecutive `match_valid` cycles, each in order with the correct vector. A `srch_valid` gap produces `match_valid` = 0 with `match` = 0.
- **Async reset mid-pipeline:** assert `rst` mid-cycle with 2 searches in flight → outputs go to 0 immediately, no `match_valid` pulses after release, and `rd_ent_valid` reads 0 for all entries.

Source files
------------

// File: rtl/tcam_pkg.sv
// Shared TCAM definitions used by the match array, the priority encoder and the
// lookup controller.
package tcam_pkg;

  localparam int TCAM_ENTRIES = 16;
  localparam int TCAM_KEY_W   = 8;

  typedef struct packed {
    logic [TCAM_KEY_W-1:0] data;
    logic [TCAM_KEY_W-1:0] mask;
    logic                  valid;
  } tcam_entry_t;

endpackage

// File: rtl/tcam_cell.sv
// One ternary entry. It holds the entry registers, decodes its own write
// address and drives a combinational match line for the registered key.
import tcam_pkg::*;

module tcam_cell #(
  parameter int AW    = 4,
  parameter int INDEX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [TCAM_KEY_W-1:0] wr_data,
  input  logic [TCAM_KEY_W-1:0] wr_mask,
  input  logic                  wr_valid,
  input  logic                  flush,
  input  logic [TCAM_KEY_W-1:0] key,
  output logic                  hit,
  output tcam_entry_t           ent
);

  localparam logic [AW-1:0] MY_ADDR = AW'(INDEX);

  logic wr_sel;

  assign wr_sel = wr_en && (wr_addr == MY_ADDR);

  // A write to this entry takes priority over a simultaneous flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else if (wr_sel) begin
      ent.data  <= wr_data;
      ent.mask  <= wr_mask;
      ent.valid <= wr_valid;
    end else if (flush) begin
      ent.valid <= 1'b0;
    end
  end

  assign hit = ent.valid && (((key ^ ent.data) & ~ent.mask) == '0);

endmodule

// File: rtl/tcam_match_array.sv
// TCAM storage and compare stage: two-stage search pipeline producing a
// registered multi-hot match vector, plus control-plane write and read-back.
import tcam_pkg::*;

module tcam_match_array #(
  parameter int ENTRIES = TCAM_ENTRIES,
  parameter int KEY_W   = TCAM_KEY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(ENTRIES)-1:0]   wr_addr,
  input  logic [KEY_W-1:0]             wr_data,
  input  logic [KEY_W-1:0]             wr_mask,
  input  logic                         wr_valid,
  input  logic                         flush,
  input  logic                         srch_valid,
  input  logic [KEY_W-1:0]             srch_key,
  output logic [ENTRIES-1:0]           match,
  output logic                         match_valid,
  output logic                         hit,
  input  logic [$clog2(ENTRIES)-1:0]   rd_addr,
  output logic [KEY_W-1:0]             rd_data,
  output logic [KEY_W-1:0]             rd_mask,
  output logic                         rd_ent_valid
);

  localparam int AW = $clog2(ENTRIES);

  logic [KEY_W-1:0]   key_q;
  logic               srch_q;
  logic [ENTRIES-1:0] match_lines;
  tcam_entry_t        ents [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_cell
    tcam_cell #(
      .AW    (AW),
      .INDEX (i)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_mask  (wr_mask),
      .wr_valid (wr_valid),
      .flush    (flush),
      .key      (key_q),
      .hit      (match_lines[i]),
      .ent      (ents[i])
    );
  end

  // Stage 1 captures the key on the same edge that commits any write, so a
  // same-cycle write is already in the array when stage 2 compares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= '0;
      srch_q <= 1'b0;
    end else begin
      key_q  <= srch_key;
      srch_q <= srch_valid;
    end
  end

  // Outputs are forced to zero in idle cycles so no stale hits are presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match       <= '0;
      hit         <= 1'b0;
      match_valid <= 1'b0;
    end else begin
      match       <= srch_q ? match_lines : '0;
      hit         <= srch_q && (|match_lines);
      match_valid <= srch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data      <= '0;
      rd_mask      <= '0;
      rd_ent_valid <= 1'b0;
    end else begin
      rd_data      <= ents[rd_addr].data;
      rd_mask      <= ents[rd_addr].mask;
      rd_ent_valid <= ents[rd_addr].valid;
    end
  end

endmodule

// File: tb/tb_tcam_match_array.sv
// Scoreboard bench for tcam_match_array: searches push expected vectors with
// their due cycle, a negedge monitor pops and compares them.
module tb_tcam_match_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic        wr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        srch_valid = 1'b0;
  logic [7:0]  srch_key = '0;
  logic [15:0] match;
  logic        match_valid;
  logic        hit;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_data;
  logic [7:0]  rd_mask;
  logic        rd_ent_valid;

  typedef struct {
    int          due;
    logic [15:0] m;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  tcam_match_array dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .wr_valid     (wr_valid),
    .flush        (flush),
    .srch_valid   (srch_valid),
    .srch_key     (srch_key),
    .match        (match),
    .match_valid  (match_valid),
    .hit          (hit),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_mask      (rd_mask),
    .rd_ent_valid (rd_ent_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Each presented result must be the oldest expectation and arrive exactly
  // on its due cycle; idle cycles must show an all-zero match vector.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (match_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_result cyc=%0d match=%h required=no result", cyc, match);
        end else begin
          e = sbq.pop_front();
          if (e.due != cyc || match !== e.m || hit !== (|e.m)) begin
            errors++;
            $display("[TB] FAIL search_result cyc=%0d match=%h hit=%b required cyc=%0d match=%h hit=%b",
                     cyc, match, hit, e.due, e.m, |e.m);
          end
        end
      end else begin
        checks++;
        if (match !== 16'h0 || hit !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_outputs cyc=%0d match=%h hit=%b required 0000/0", cyc, match, hit);
        end
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          checks++;
          errors++;
          e = sbq.pop_front();
          $display("[TB] FAIL missing_result cyc=%0d match_valid=0 required match=%h due=%0d", cyc, e.m, e.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Drives one cycle of stimulus; a search with push=1 queues its expected vector.
  task automatic applyStimulus(input logic do_srch, input logic [7:0] key,
                               input logic do_wr, input logic [3:0] addr,
                               input logic [7:0] data, input logic [7:0] mask,
                               input logic valid, input logic do_flush,
                               input logic [15:0] exp_match, input logic push);
    exp_t e;
    srch_valid = do_srch;
    srch_key   = key;
    wr_en      = do_wr;
    wr_addr    = addr;
    wr_data    = data;
    wr_mask    = mask;
    wr_valid   = valid;
    flush      = do_flush;
    if (do_srch && push) begin
      e.due = cyc + 2;
      e.m   = exp_match;
      sbq.push_back(e);
    end
    step();
    srch_valid = 1'b0;
    wr_en      = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic search(input logic [7:0] key, input logic [15:0] exp_match);
    applyStimulus(1'b1, key, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, exp_match, 1'b1);
  endtask

  task automatic write(input logic [3:0] addr, input logic [7:0] data, input logic [7:0] mask, input logic valid);
    applyStimulus(1'b0, 8'h00, 1'b1, addr, data, mask, valid, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_match", {16'h0, match}, 32'h0);
    checkOutput("reset_match_valid", {31'h0, match_valid}, 32'h0);
    checkOutput("reset_rd_data", {24'h0, rd_data}, 32'h0);
    checkOutput("reset_rd_mask", {24'h0, rd_mask}, 32'h0);
    checkOutput("reset_rd_ent_valid", {31'h0, rd_ent_valid}, 32'h0);

    search(8'hAA, 16'h0000);
    idle();
    idle();

    write(4'd3, 8'h5A, 8'h00, 1'b1);
    write(4'd12, 8'h50, 8'h0F, 1'b1);
    search(8'h5A, 16'h1008);
    search(8'h57, 16'h1000);
    search(8'h60, 16'h0000);
    search(8'h5F, 16'h1000);
    idle();
    search(8'h5A, 16'h1008);
    idle();
    idle();

    applyStimulus(1'b1, 8'h11, 1'b1, 4'd7, 8'h11, 8'h00, 1'b1, 1'b0, 16'h0080, 1'b1);
    write(4'd7, 8'h11, 8'h00, 1'b0);
    search(8'h11, 16'h0000);
    write(4'd7, 8'h11, 8'h00, 1'b1);
    search(8'h11, 16'h0080);
    idle();
    idle();

    for (int i = 0; i < 16; i++) write(4'(i), 8'h00, 8'hFF, 1'b1);
    search(8'h00, 16'hFFFF);
    applyStimulus(1'b1, 8'h33, 1'b1, 4'd5, 8'h00, 8'hFF, 1'b1, 1'b1, 16'h0020, 1'b1);
    search(8'hC3, 16'h0020);
    idle();
    idle();

    // Read-back returns the old contents when written in the same cycle.
    rd_addr = 4'd5;
    write(4'd5, 8'hA5, 8'h0F, 1'b1);
    checkOutput("rd_old_data", {24'h0, rd_data}, 32'h00);
    checkOutput("rd_old_mask", {24'h0, rd_mask}, 32'hFF);
    checkOutput("rd_old_valid", {31'h0, rd_ent_valid}, 32'h1);
    idle();
    checkOutput("rd_new_data", {24'h0, rd_data}, 32'hA5);
    checkOutput("rd_new_mask", {24'h0, rd_mask}, 32'h0F);
    rd_addr = 4'd6;
    idle();
    checkOutput("rd_flushed_valid", {31'h0, rd_ent_valid}, 32'h0);
    checkOutput("rd_flushed_mask", {24'h0, rd_mask}, 32'hFF);
    search(8'hA7, 16'h0020);
    idle();
    idle();

    // Two searches in flight, then reset lands mid-cycle.
    applyStimulus(1'b1, 8'hA0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 8'hA1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0);
    checkOutput("inflight_match_valid", {31'h0, match_valid}, 32'h1);
    checkOutput("inflight_match", {16'h0, match}, 32'h0020);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_match_valid", {31'h0, match_valid}, 32'h0);
    checkOutput("async_match", {16'h0, match}, 32'h0);
    checkOutput("async_hit", {31'h0, hit}, 32'h0);
    step();
    step();
    rst = 1'b0;
    repeat (5) idle();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      idle();
      checkOutput($sformatf("post_reset_valid_%0d", i), {31'h0, rd_ent_valid}, 32'h0);
    end
    checkOutput("post_reset_rd_data", {24'h0, rd_data}, 32'h0);

    repeat (4) idle();
    checkOutput("scoreboard_drained", sbq.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
